// File: rtl/tag_packetizer.sv
// rtl/tag_packetizer.sv - timestamp record FIFO and MSB-first byte serializer for the host output mux
//
// Ports:
//   clk_i        single clock
//   nreset_i     asynchronous active-low reset
//   rec_i        record from the tagger, byte REC_BYTES-1 is sent first
//   rec_valid_i  rec_i valid this cycle
//   rec_ready_o  FIFO not full; push accepted on rec_valid_i && rec_ready_o
//   omux_data_o  byte presented to the mux
//   omux_req_o   request to the mux
//   omux_sel_i   one-cycle grant; presented byte consumed this cycle
//   level_o      records held in the FIFO, excluding the one being serialized
//   drop_cnt_o   saturating count of records rejected while full
//   drop_clr_i   synchronous clear of drop_cnt_o
module tag_packetizer #(
    parameter int REC_BYTES = 6,
    parameter int FIFO_AW   = 4
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic [8*REC_BYTES-1:0] rec_i,
    input  logic                   rec_valid_i,
    output logic                   rec_ready_o,
    output logic [7:0]             omux_data_o,
    output logic                   omux_req_o,
    input  logic                   omux_sel_i,
    output logic [FIFO_AW:0]       level_o,
    output logic [15:0]            drop_cnt_o,
    input  logic                   drop_clr_i
);

    localparam int RW    = 8 * REC_BYTES;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BCW   = $clog2(REC_BYTES);
    localparam logic [BCW-1:0]   BC_LAST = BCW'(REC_BYTES - 1);
    localparam logic [FIFO_AW:0] FULL    = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic [RW-1:0]        sr_q;
    logic [BCW-1:0]       bc_q;
    logic [15:0]          drop_q;
    logic                 push;
    logic                 pop;
    logic                 last_grant;

    // Ready depends only on the registered count, so a same-cycle pop never reopens a full FIFO.
    assign rec_ready_o = (count_q != FULL);
    assign push        = rec_valid_i && rec_ready_o;
    assign level_o     = count_q;
    assign drop_cnt_o  = drop_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The request drops combinationally on the last grant so the mux goes idle instead of
    // re-entering its send state; the forced IDLE cycle lets other sources win arbitration.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        last_grant  = 1'b0;
        omux_req_o  = 1'b0;
        omux_data_o = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                omux_data_o = sr_q[RW-1 -: 8];
                last_grant  = omux_sel_i && (bc_q == BC_LAST);
                omux_req_o  = !last_grant;
                if (last_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sr_q <= '0;
            bc_q <= '0;
        end else if (pop) begin
            sr_q <= mem[rd_ptr_q];
            bc_q <= '0;
        end else if ((state_q == ST_SEND) && omux_sel_i && !last_grant) begin
            sr_q <= sr_q << 8;
            bc_q <= bc_q + 1'b1;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= rec_i;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            drop_q <= '0;
        end else if (drop_clr_i) begin
            drop_q <= '0;
        end else if (rec_valid_i && !rec_ready_o && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_tag_packetizer.sv
// tb/tb_tag_packetizer.sv - scoreboard bench for tag_packetizer with a grant-pattern mux model
module tb_tag_packetizer;

    localparam int RB = 6;
    localparam int AW = 2;

    logic            clk_i       = 1'b0;
    logic            nreset_i    = 1'b0;
    logic [8*RB-1:0] rec_i       = '0;
    logic            rec_valid_i = 1'b0;
    logic            rec_ready_o;
    logic [7:0]      omux_data_o;
    logic            omux_req_o;
    logic            omux_sel_i  = 1'b0;
    logic [AW:0]     level_o;
    logic [15:0]     drop_cnt_o;
    logic            drop_clr_i  = 1'b0;

    int checks     = 0;
    int failures   = 0;
    int grant_mode = 0;   // 0 off, >0 grant every Nth cycle, <0 random
    int grant_limit = -1; // grants remaining, -1 unlimited
    int mux_cyc    = 0;
    int mon_idx    = 0;
    bit after_last = 1'b0;
    logic [7:0] exp_q [$];

    tag_packetizer #(.REC_BYTES(RB), .FIFO_AW(AW)) dut (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .rec_i       (rec_i),
        .rec_valid_i (rec_valid_i),
        .rec_ready_o (rec_ready_o),
        .omux_data_o (omux_data_o),
        .omux_req_o  (omux_req_o),
        .omux_sel_i  (omux_sel_i),
        .level_o     (level_o),
        .drop_cnt_o  (drop_cnt_o),
        .drop_clr_i  (drop_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [8*RB-1:0] r);
        for (int i = RB - 1; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_rec(input logic [8*RB-1:0] r, input bit acc);
        rec_i       = r;
        rec_valid_i = 1'b1;
        chk("ready_at_push", rec_ready_o, acc);
        if (acc) sb_push(r);
        step();
        rec_valid_i = 1'b0;
    endtask

    task automatic push_wait(input logic [8*RB-1:0] r);
        int n;
        n = 0;
        while (!rec_ready_o && n < 500) begin
            step();
            n++;
        end
        chk("push_wait_timeout", n < 500, 1);
        rec_i       = r;
        rec_valid_i = 1'b1;
        sb_push(r);
        step();
        rec_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || omux_req_o) && n < limit) begin
            step();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        step();
        step();
    endtask

    // Mux model: clears the grant, then grants for one cycle when requested and the pattern allows.
    always @(posedge clk_i) begin
        #1 omux_sel_i = 1'b0;
        #1 mux_cyc++;
        if (omux_req_o && grant_limit != 0) begin
            if ((grant_mode > 0 && (mux_cyc % grant_mode) == 0) ||
                (grant_mode < 0 && $urandom_range(0, 2) == 0)) begin
                omux_sel_i = 1'b1;
                if (grant_limit > 0) grant_limit--;
            end
        end
    end

    // Monitor: every granted byte is popped from the scoreboard and compared.
    always @(negedge clk_i) begin
        logic [7:0] eb;
        if (nreset_i) begin
            if (after_last) begin
                chk("idle_after_last_req", omux_req_o, 0);
                after_last = 1'b0;
            end
            if (omux_sel_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none at %0t", omux_data_o, $time);
                end else begin
                    eb = exp_q.pop_front();
                    chk("byte", omux_data_o, eb);
                    chk("req_on_grant", omux_req_o, (mon_idx != RB - 1));
                    if (mon_idx == RB - 1) begin
                        after_last = 1'b1;
                        mon_idx    = 0;
                    end else begin
                        mon_idx++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [8*RB-1:0] r;

        // Reset state
        #12;
        chk("rst_req", omux_req_o, 0);
        chk("rst_data", omux_data_o, 0);
        chk("rst_ready", rec_ready_o, 1);
        chk("rst_level", level_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        step();
        nreset_i = 1'b1;
        step();

        // Single record, grant every 3rd cycle
        grant_mode = 3;
        push_rec(48'h0A1B2C3D4E5F, 1'b1);
        chk("single_level_after_push", level_o, 1);
        step();
        chk("single_req_after_load", omux_req_o, 1);
        chk("single_first_byte", omux_data_o, 8'h0A);
        chk("single_level_after_load", level_o, 0);
        wait_drain(200);

        // Back-to-back records, grant every cycle; check req/level trace per cycle
        grant_mode = 1;
        sb_push(48'h111213141516);
        sb_push(48'h212223242526);
        sb_push(48'h313233343536);
        rec_i = 48'h111213141516;
        rec_valid_i = 1'b1;
        step();
        rec_i = 48'h212223242526;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk_i);
            chk($sformatf("b2b_req_k%0d", k), omux_req_o, !((k % 7) == 0 || (k % 7) == 6));
            chk($sformatf("b2b_level_k%0d", k), level_o, (k < 2) ? 1 : (k < 8) ? 2 : (k < 15) ? 1 : 0);
            step();
            if (k == 0) rec_i = 48'h313233343536;
            if (k == 1) rec_valid_i = 1'b0;
        end
        wait_drain(200);

        // Overflow: grants held off, 7 pushes, last two rejected
        grant_mode = 0;
        for (int i = 0; i < 7; i++) begin
            r = {6{8'(8'h40 + i)}};
            push_rec(r, i < 5);
        end
        chk("ovf_drop", drop_cnt_o, 2);
        chk("ovf_ready", rec_ready_o, 0);
        chk("ovf_level", level_o, 4);
        grant_mode = 1;
        wait_drain(300);
        chk("ovf_level_drained", level_o, 0);
        chk("ovf_ready_drained", rec_ready_o, 1);

        // Clear beats a simultaneous drop, then saturation
        grant_mode = 0;
        for (int i = 0; i < 5; i++) push_rec({6{8'(8'h60 + i)}}, 1'b1);
        push_rec(48'hDEADDEADDEAD, 1'b0);
        chk("drop_before_clr", drop_cnt_o, 3);
        drop_clr_i  = 1'b1;
        rec_valid_i = 1'b1;
        step();
        chk("clr_and_drop", drop_cnt_o, 0);
        drop_clr_i = 1'b0;
        repeat (65537) @(posedge clk_i);
        #1;
        chk("drop_saturated", drop_cnt_o, 16'hFFFF);
        step();
        chk("drop_stays_saturated", drop_cnt_o, 16'hFFFF);
        drop_clr_i = 1'b1;
        step();
        chk("drop_cleared", drop_cnt_o, 0);
        drop_clr_i  = 1'b0;
        rec_valid_i = 1'b0;
        grant_mode  = 1;
        wait_drain(300);

        // Pointer wrap: 20 records with random grant gaps
        grant_mode = -1;
        for (int i = 0; i < 20; i++) begin
            r = {8'(i), 8'(i + 8'h80), 8'(i * 3), 8'(8'hF0 - i), 8'(i ^ 8'h5A), 8'(i + 1)};
            push_wait(r);
        end
        wait_drain(3000);
        chk("wrap_drop", drop_cnt_o, 0);
        chk("wrap_level", level_o, 0);

        // Reset in the middle of a record with two more queued
        grant_mode = 0;
        push_rec(48'hA1A2A3A4A5A6, 1'b1);
        push_rec(48'hB1B2B3B4B5B6, 1'b1);
        push_rec(48'hC1C2C3C4C5C6, 1'b1);
        grant_limit = 3;
        grant_mode  = 1;
        begin
            int n;
            n = 0;
            while (!(grant_limit == 0 && mon_idx == 3) && n < 50) begin
                step();
                n++;
            end
            chk("midrec_reach_byte3", n < 50, 1);
        end
        #2;
        nreset_i = 1'b0;
        #1;
        chk("midrec_rst_req", omux_req_o, 0);
        chk("midrec_rst_level", level_o, 0);
        chk("midrec_rst_ready", rec_ready_o, 1);
        chk("midrec_rst_data", omux_data_o, 0);
        exp_q.delete();
        mon_idx    = 0;
        after_last = 1'b0;
        grant_limit = -1;
        step();
        step();
        nreset_i = 1'b1;
        step();
        chk("post_rst_req", omux_req_o, 0);
        push_rec(48'h0F1E2D3C4B5A, 1'b1);
        wait_drain(200);
        chk("post_rst_level", level_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
